instr_fetch: RTL and testbench

- Initiator side of the instruction-memory read interface: owns the program counter, drives the 7-bit byte address and read enable into the instruction ROM, and captures the 32-bit word returned in the same cycle.
- Presents each word to decode over a valid/ready handshake with its PC.
- Sits between the instruction ROM and the decode stage.
- Accepts branch/jump redirects from execute.

---
 rtl/instr_fetch.sv | 82 ++++++++
 tb/tb_instr_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads the instruction ROM combinationally and
// hands words to decode over valid/ready. Optional halt-on-empty-slot via INSTR_FETCH_HALT_EN.
module instr_fetch #(
   parameter int                ADDR_W   = 7,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(4),
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] rom_address,
   output logic              rom_en,
   input  logic [31:0]       rom_out,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
`ifdef INSTR_FETCH_HALT_EN
   output logic              halted,
`endif
   output logic              misaligned
);

   logic [ADDR_W-1:0] pc;
   logic              load;
   logic              halt_blk;

`ifdef INSTR_FETCH_HALT_EN
   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
   state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // An all-zero word marks an empty ROM slot: deliver it, then stop until redirected.
   always_comb begin
      state_nxt = state;
      if (redirect_valid)
         state_nxt = RUN;
      else if (load && rom_out == 32'h0)
         state_nxt = HALT;
   end

   assign halt_blk = (state == HALT);
   assign halted   = halt_blk;
`else
   assign halt_blk = 1'b0;
`endif

   assign load        = fetch_en & (~instr_valid | instr_ready) & ~redirect_valid & ~halt_blk;
   // Gate with reset so the ROM is never read while the block is held in reset.
   assign rom_en      = load & rst_n;
   assign rom_address = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         instr       <= 32'h0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         misaligned  <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect wins over load and stall; any held word is dropped.
         instr_valid <= 1'b0;
         pc          <= {redirect_pc[ADDR_W-1:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00)
            misaligned <= 1'b1;
      end else if (load) begin
         instr       <= rom_out;
         instr_pc    <= pc;
         instr_valid <= 1'b1;
         pc          <= pc + ADDR_W'(PC_STEP);
      end else if (instr_valid && instr_ready) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan steps followed by
// random traffic, all compared against a transaction-level fetch model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en, redirect_valid, instr_ready;
   logic [6:0]  redirect_pc;
   logic [6:0]  rom_address, instr_pc;
   logic        rom_en, instr_valid, misaligned;
   logic [31:0] rom_out, instr;
`ifdef INSTR_FETCH_HALT_EN
   logic        halted;
`endif

   logic [31:0] rom [32];
   assign rom_out = rom[rom_address[6:2]];

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .rom_address(rom_address), .rom_en(rom_en), .rom_out(rom_out),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready),
`ifdef INSTR_FETCH_HALT_EN
      .halted(halted),
`endif
      .misaligned(misaligned)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_pc;
   bit          m_valid, m_mis, m_halt;
   logic [31:0] m_instr;
   int          m_ipc;
   bit          halt_en;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 4; m_valid = 0; m_mis = 0; m_halt = 0; m_instr = 0; m_ipc = 0;
   endtask

   task automatic check_regs();
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("instr_pc", {25'b0, instr_pc}, 32'(m_ipc));
      chk("instr", instr, m_instr);
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
`ifdef INSTR_FETCH_HALT_EN
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
`endif
   endtask

   // One clock: drive, check combinational ROM side, clock, advance model, check outputs.
   task automatic step(input bit fe, input bit rv, input int rpc, input bit rdy);
      bit exp_load;
      fetch_en = fe; redirect_valid = rv; redirect_pc = 7'(rpc); instr_ready = rdy;
      #1;
      exp_load = fe && (!m_valid || rdy) && !rv && !m_halt;
      chk("rom_en", {31'b0, rom_en}, {31'b0, exp_load});
      chk("rom_address", {25'b0, rom_address}, 32'(m_pc));
      @(posedge clk);
      if (rv) begin
         m_valid = 0;
         m_pc    = rpc & 124;
         if ((rpc & 3) != 0) m_mis = 1;
         m_halt  = 0;
      end else if (exp_load) begin
         m_instr = rom[m_pc / 4];
         m_ipc   = m_pc;
         m_valid = 1;
         if (halt_en && m_instr == 32'h0) m_halt = 1;
         m_pc    = (m_pc + 4) % 128;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      #1;
      check_regs();
   endtask

   initial begin
`ifdef INSTR_FETCH_HALT_EN
      halt_en = 1;
`else
      halt_en = 0;
`endif
      for (int i = 0; i < 32; i++) rom[i] = $urandom | 32'h1;
      rom[1] = 32'h00348093;
      rom[2] = 32'h00118393;

      // reset with fetch enabled: ROM must stay idle
      rst_n = 1'b0; fetch_en = 1; redirect_valid = 0; redirect_pc = 0; instr_ready = 1;
      model_reset();
      #12;
      chk("reset rom_en", {31'b0, rom_en}, 32'h0);
      chk("reset rom_address", {25'b0, rom_address}, 32'd4);
      check_regs();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;   // first edge after release already fetches
      m_instr = rom[1]; m_ipc = 4; m_valid = 1; m_pc = 8;
      chk("first instr", instr, 32'h00348093);
      check_regs();
      step(1, 0, 0, 1);
      chk("second instr", instr, 32'h00118393);
      chk("second pc", {25'b0, instr_pc}, 32'd8);

      // backpressure: three stalled cycles then release
      step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
      chk("stall pc", {25'b0, rom_address}, 32'd12);
      step(1, 0, 0, 1);
      chk("after stall pc", {25'b0, instr_pc}, 32'd12);

      // run to pc 16 then redirect while stalled
      step(1, 0, 0, 1);
      chk("at 16", {25'b0, instr_pc}, 32'd16);
      step(1, 1, 8, 0);
      chk("redirect drops valid", {31'b0, instr_valid}, 32'h0);
      step(1, 0, 0, 1);
      chk("redirect target", {25'b0, instr_pc}, 32'd8);

      // misaligned redirect
      step(1, 1, 14, 1);
      step(1, 0, 0, 1);
      chk("misaligned target", {25'b0, instr_pc}, 32'd12);
      chk("misaligned set", {31'b0, misaligned}, 32'h1);
      step(1, 0, 0, 1); step(1, 0, 0, 1);
      chk("misaligned sticky", {31'b0, misaligned}, 32'h1);

      // wrap 124 -> 0 -> 4
      step(1, 1, 124, 1);
      step(1, 0, 0, 1); chk("wrap 124", {25'b0, instr_pc}, 32'd124);
      step(1, 0, 0, 1); chk("wrap 0", {25'b0, instr_pc}, 32'd0);
      step(1, 0, 0, 1); chk("wrap 4", {25'b0, instr_pc}, 32'd4);

      // fetch_en low: held word stays until accepted, pc frozen
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("drain no refill", {31'b0, instr_valid}, 32'h0);
      step(1, 0, 0, 1);

      // simultaneous redirect and ready
      step(1, 1, 40, 1);
      step(1, 0, 0, 1);
      chk("redirect+ready", {25'b0, instr_pc}, 32'd40);

`ifdef INSTR_FETCH_HALT_EN
      rom[5] = 32'h0;
      step(1, 1, 4, 1);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
      chk("halt flag", {31'b0, halted}, 32'h1);
      step(1, 1, 4, 1);
      chk("halt cleared", {31'b0, halted}, 32'h0);
      step(1, 0, 0, 1);
      chk("resume at 4", {25'b0, instr_pc}, 32'd4);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) rom[$urandom_range(31)] = halt_en ? 32'h0 : $urandom;
         step(($urandom % 8) != 0, ($urandom % 12) == 0, int'($urandom % 128), ($urandom % 4) != 0);
      end

      // async reset mid-run
      #3; rst_n = 1'b0; #1;
      model_reset();
      chk("midreset rom_en", {31'b0, rom_en}, 32'h0);
      chk("midreset rom_address", {25'b0, rom_address}, 32'd4);
      check_regs();
      @(negedge clk); rst_n = 1'b1;
      step(1, 0, 0, 1);
      chk("post reset pc", {25'b0, instr_pc}, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
